flip_flop_d: RTL and testbench

FLIP_FLOP_D -- requirements
Module: flip_flop_d

---
 rtl/flip_flop_d.sv | 38 +++
 tb/tb_flip_flop_d.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flip_flop_d.sv
// Positive-edge D register with synchronous reset, optional capture enable,
// a complemented output and a one-cycle "value changed" flag.
module flip_flop_d #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               HAS_ENABLE  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q1,
    output logic             changed
);

    logic capture;

    // Without an enable every rising edge is a capture edge.
    assign capture = HAS_ENABLE ? en : 1'b1;

    // NOTE: non-blocking assignments so changed compares D against the old Q,
    // not the value being written at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q       <= RESET_VALUE;
            changed <= 1'b0;
        end else begin
            changed <= capture && (D != Q);
            if (capture) begin
                Q <= D;
            end
        end
    end

    assign Q1 = ~Q;

endmodule

// File: tb/tb_flip_flop_d.sv
// Scoreboard bench for flip_flop_d: default 1-bit instance, an 8-bit instance
// with reset value A5, and an 8-bit instance without enable, driven in lockstep.
module tb_flip_flop_d;

    logic       clk;
    logic       clk_run;
    logic       reset;
    logic       en;
    logic [7:0] d;

    logic [0:0] q_a, qb_a;
    logic       ch_a;
    logic [7:0] q_b, qb_b;
    logic       ch_b;
    logic [7:0] q_c, qb_c;
    logic       ch_c;

    flip_flop_d u_dut_a (
        .clk(clk), .reset(reset), .en(en), .D(d[0:0]),
        .Q(q_a), .Q1(qb_a), .changed(ch_a)
    );

    flip_flop_d #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .D(d),
        .Q(q_b), .Q1(qb_b), .changed(ch_b)
    );

    flip_flop_d #(.WIDTH(8), .RESET_VALUE(8'h00), .HAS_ENABLE(1'b0)) u_dut_c (
        .clk(clk), .reset(reset), .en(en), .D(d),
        .Q(q_c), .Q1(qb_c), .changed(ch_c)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    typedef struct packed {
        logic [0:0] a_q;
        logic       a_c;
        logic [7:0] b_q;
        logic       b_c;
        logic [7:0] c_q;
        logic       c_c;
    } exp_t;

    exp_t       sb[$];
    logic [0:0] m_a;
    logic [7:0] m_b, m_c;
    int         checks = 0;
    int         errors = 0;

    // Drive one edge's worth of inputs and push what each instance should show after it.
    task automatic apply(input logic r, input logic e, input logic [7:0] v);
        exp_t x;
        reset = r;
        en    = e;
        d     = v;
        x.a_c = !r && e && (v[0] != m_a[0]);
        m_a   = r ? 1'b0 : (e ? v[0:0] : m_a);
        x.a_q = m_a;
        x.b_c = !r && e && (v != m_b);
        m_b   = r ? 8'hA5 : (e ? v : m_b);
        x.b_q = m_b;
        x.c_c = !r && (v != m_c);
        m_c   = r ? 8'h00 : v;
        x.c_q = m_c;
        sb.push_back(x);
    endtask

    task automatic tick(output exp_t x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            x = '0;
        end else begin
            x = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t x;
        apply(1'b1, 1'b0, 8'h00);
        tick(x);
        checks++;
        if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c) begin
            errors++;
            $display("FAIL reset_w1: got Q=%b Q1=%b changed=%b, expected Q=%b Q1=%b changed=%b",
                     q_a, qb_a, ch_a, x.a_q, ~x.a_q, x.a_c);
        end
        checks++;
        if (q_b !== x.b_q || qb_b !== ~x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL reset_w8: got Q=%h Q1=%h changed=%b, expected Q=%h Q1=%h changed=%b",
                     q_b, qb_b, ch_b, x.b_q, ~x.b_q, x.b_c);
        end
        checks++;
        if (q_c !== x.c_q || qb_c !== ~x.c_q || ch_c !== x.c_c) begin
            errors++;
            $display("FAIL reset_noen: got Q=%h Q1=%h changed=%b, expected Q=%h Q1=%h changed=%b",
                     q_c, qb_c, ch_c, x.c_q, ~x.c_q, x.c_c);
        end
    endtask

    task automatic test_stable_high();
        exp_t x;
        apply(1'b0, 1'b1, 8'h00);
        tick(x);
        checks++;
        if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c) begin
            errors++;
            $display("FAIL capture_zero: got Q=%b Q1=%b changed=%b, expected Q=%b Q1=%b changed=%b",
                     q_a, qb_a, ch_a, x.a_q, ~x.a_q, x.a_c);
        end
        // Freeze the clock high and wiggle D; nothing may move.
        clk_run = 1'b0;
        d = 8'hFF;
        #100;
        checks++;
        if (clk !== 1'b1 || q_a !== x.a_q || qb_a !== ~x.a_q || q_b !== x.b_q || q_c !== x.c_q) begin
            errors++;
            $display("FAIL clk_high_transparent: got clk=%b Q=%b Q1=%b Qb=%h Qc=%h, expected clk=1 Q=%b Q1=%b Qb=%h Qc=%h",
                     clk, q_a, qb_a, q_b, q_c, x.a_q, ~x.a_q, x.b_q, x.c_q);
        end
        d = 8'h00;
        clk_run = 1'b1;
    endtask

    task automatic test_rising_edge();
        exp_t x;
        @(negedge clk);
        #1;
        apply(1'b0, 1'b1, 8'h01);
        tick(x);
        checks++;
        if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c || q_b !== x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL capture_one: got Q=%b Q1=%b changed=%b Qb=%h chb=%b, expected Q=%b Q1=%b changed=%b Qb=%h chb=%b",
                     q_a, qb_a, ch_a, q_b, ch_b, x.a_q, ~x.a_q, x.a_c, x.b_q, x.b_c);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c || q_b !== x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL falling_edge_update: got Q=%b Q1=%b changed=%b Qb=%h chb=%b, expected Q=%b Q1=%b changed=%b Qb=%h chb=%b",
                     q_a, qb_a, ch_a, q_b, ch_b, x.a_q, ~x.a_q, x.a_c, x.b_q, x.b_c);
        end
        apply(1'b0, 1'b1, 8'h01);
        tick(x);
        checks++;
        if (q_a !== x.a_q || ch_a !== x.a_c || q_b !== x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL same_value_changed: got Q=%b changed=%b Qb=%h chb=%b, expected Q=%b changed=%b Qb=%h chb=%b",
                     q_a, ch_a, q_b, ch_b, x.a_q, x.a_c, x.b_q, x.b_c);
        end
    endtask

    task automatic test_hold();
        exp_t x;
        logic [7:0] pat [3] = '{8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, pat[i]);
            tick(x);
            checks++;
            if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c || q_b !== x.b_q || ch_b !== x.b_c) begin
                errors++;
                $display("FAIL hold_%0d: got Q=%b changed=%b Qb=%h chb=%b, expected Q=%b changed=%b Qb=%h chb=%b",
                         i, q_a, ch_a, q_b, ch_b, x.a_q, x.a_c, x.b_q, x.b_c);
            end
            checks++;
            if (q_c !== x.c_q || qb_c !== ~x.c_q || ch_c !== x.c_c) begin
                errors++;
                $display("FAIL noen_follow_%0d: got Q=%h Q1=%h changed=%b, expected Q=%h Q1=%h changed=%b",
                         i, q_c, qb_c, ch_c, x.c_q, ~x.c_q, x.c_c);
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_t x;
        apply(1'b1, 1'b1, 8'hFF);
        tick(x);
        checks++;
        if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c || q_b !== x.b_q || q_c !== x.c_q) begin
            errors++;
            $display("FAIL reset_priority: got Q=%b Q1=%b changed=%b Qb=%h Qc=%h, expected Q=%b Q1=%b changed=%b Qb=%h Qc=%h",
                     q_a, qb_a, ch_a, q_b, q_c, x.a_q, ~x.a_q, x.a_c, x.b_q, x.c_q);
        end
        apply(1'b0, 1'b1, 8'hFF);
        tick(x);
        checks++;
        if (q_a !== x.a_q || ch_a !== x.a_c || q_b !== x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL recapture_ff: got Q=%b changed=%b Qb=%h chb=%b, expected Q=%b changed=%b Qb=%h chb=%b",
                     q_a, ch_a, q_b, ch_b, x.a_q, x.a_c, x.b_q, x.b_c);
        end
        // Reset pulse between edges must be invisible.
        #1 reset = 1'b1;
        #2;
        checks++;
        if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c || q_b !== x.b_q || q_c !== x.c_q) begin
            errors++;
            $display("FAIL midcycle_reset: got Q=%b Q1=%b changed=%b Qb=%h Qc=%h, expected Q=%b Q1=%b changed=%b Qb=%h Qc=%h",
                     q_a, qb_a, ch_a, q_b, q_c, x.a_q, ~x.a_q, x.a_c, x.b_q, x.c_q);
        end
        reset = 1'b0;
        apply(1'b0, 1'b0, 8'h00);
        tick(x);
        checks++;
        if (q_a !== x.a_q || q_b !== x.b_q || q_c !== x.c_q || ch_c !== x.c_c) begin
            errors++;
            $display("FAIL after_pulse: got Q=%b Qb=%h Qc=%h chc=%b, expected Q=%b Qb=%h Qc=%h chc=%b",
                     q_a, q_b, q_c, ch_c, x.a_q, x.b_q, x.c_q, x.c_c);
        end
    endtask

    task automatic test_width();
        exp_t x;
        apply(1'b1, 1'b0, 8'h00);
        tick(x);
        checks++;
        if (q_b !== x.b_q || qb_b !== ~x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL w8_reset_a5: got Q=%h Q1=%h changed=%b, expected Q=%h Q1=%h changed=%b",
                     q_b, qb_b, ch_b, x.b_q, ~x.b_q, x.b_c);
        end
        apply(1'b0, 1'b1, 8'h3C);
        tick(x);
        checks++;
        if (q_b !== x.b_q || qb_b !== ~x.b_q || ch_b !== x.b_c) begin
            errors++;
            $display("FAIL w8_capture_3c: got Q=%h Q1=%h changed=%b, expected Q=%h Q1=%h changed=%b",
                     q_b, qb_b, ch_b, x.b_q, ~x.b_q, x.b_c);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        logic [7:0] v;
        logic       r, e;
        for (int i = 0; i < 32; i++) begin
            r = ($urandom_range(0, 7) == 0);
            e = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0) ? d : 8'($urandom_range(0, 255));
            apply(r, e, v);
            tick(x);
            checks++;
            if (q_a !== x.a_q || qb_a !== ~x.a_q || ch_a !== x.a_c ||
                q_b !== x.b_q || qb_b !== ~x.b_q || ch_b !== x.b_c ||
                q_c !== x.c_q || qb_c !== ~x.c_q || ch_c !== x.c_c) begin
                errors++;
                $display("FAIL b2b_%0d: got %b/%b %h/%b %h/%b, expected %b/%b %h/%b %h/%b",
                         i, q_a, ch_a, q_b, ch_b, q_c, ch_c,
                         x.a_q, x.a_c, x.b_q, x.b_c, x.c_q, x.c_c);
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by 50000, expected earlier finish");
        $fatal(1, "timeout");
    end

    initial begin
        clk_run = 1'b1;
        reset   = 1'b0;
        en      = 1'b0;
        d       = 8'h00;
        m_a     = 1'b0;
        m_b     = 8'h00;
        m_c     = 8'h00;
        #2;
        test_reset();
        test_stable_high();
        test_rising_edge();
        test_hold();
        test_reset_priority();
        test_width();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
